// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the DRAM arbiter.
//   DWIDTH / SWIDTH : data and byte-strobe widths (data width follows the project-wide
//                     `DWIDTH macro normally provided by gDefine.svh; 32 if it is absent)
//   NUM_REQ_DEFAULT : default number of requester ports
//   arb_state_t     : per-side arbitration FSM state (IDLE -> ADDR -> DATA -> IDLE)
`ifndef DWIDTH
`define DWIDTH 32
`endif

package dram_arb_pkg;

    localparam int unsigned DWIDTH          = `DWIDTH;
    localparam int unsigned SWIDTH          = DWIDTH / 8;
    localparam int unsigned NUM_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: requester-side and DRAM-side handshake bundle of the arbiter.
//   req_* : NUM_REQ requester ports (read address/data, write address/data)
//   m_*   : single DRAM master port (read address/data, write address/data)
//   modport slave  : the arbiter's view (takes requests, drives the DRAM port)
//   modport master : the environment's view (requesters plus DRAM)
interface dram_arbiter_if #(
    parameter int unsigned NUM_REQ     = dram_arb_pkg::NUM_REQ_DEFAULT,
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned BURST_WIDTH = 8
) ();
    import dram_arb_pkg::*;

    // requester read side
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_rAddr;
    logic [NUM_REQ-1:0][BURST_WIDTH-1:0] req_arLen;
    logic [NUM_REQ-1:0]                  req_arValid;
    logic [NUM_REQ-1:0]                  req_arReady;
    logic [NUM_REQ-1:0][DWIDTH-1:0]      req_rData;
    logic [NUM_REQ-1:0]                  req_rValid;
    logic [NUM_REQ-1:0]                  req_rLast;
    logic [NUM_REQ-1:0]                  req_rReady;
    // requester write side
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_wAddr;
    logic [NUM_REQ-1:0][BURST_WIDTH-1:0] req_awLen;
    logic [NUM_REQ-1:0]                  req_awValid;
    logic [NUM_REQ-1:0]                  req_awReady;
    logic [NUM_REQ-1:0][DWIDTH-1:0]      req_wData;
    logic [NUM_REQ-1:0][SWIDTH-1:0]      req_wStrb;
    logic [NUM_REQ-1:0]                  req_wValid;
    logic [NUM_REQ-1:0]                  req_wLast;
    logic [NUM_REQ-1:0]                  req_wReady;
    // DRAM read side
    logic [ADDR_WIDTH-1:0]               m_rAddr;
    logic [BURST_WIDTH-1:0]              m_arLen;
    logic                                m_arValid;
    logic                                m_arReady;
    logic [DWIDTH-1:0]                   m_rData;
    logic                                m_rValid;
    logic                                m_rLast;
    logic                                m_rReady;
    // DRAM write side
    logic [ADDR_WIDTH-1:0]               m_wAddr;
    logic [BURST_WIDTH-1:0]              m_awLen;
    logic                                m_awValid;
    logic                                m_awReady;
    logic [DWIDTH-1:0]                   m_wData;
    logic [SWIDTH-1:0]                   m_wStrb;
    logic                                m_wValid;
    logic                                m_wLast;
    logic                                m_wReady;

    modport slave (
        input  req_rAddr, req_arLen, req_arValid, req_rReady,
        input  req_wAddr, req_awLen, req_awValid, req_wData, req_wStrb, req_wValid, req_wLast,
        input  m_arReady, m_rData, m_rValid, m_rLast, m_awReady, m_wReady,
        output req_arReady, req_rData, req_rValid, req_rLast,
        output req_awReady, req_wReady,
        output m_rAddr, m_arLen, m_arValid, m_rReady,
        output m_wAddr, m_awLen, m_awValid, m_wData, m_wStrb, m_wValid, m_wLast
    );

    modport master (
        output req_rAddr, req_arLen, req_arValid, req_rReady,
        output req_wAddr, req_awLen, req_awValid, req_wData, req_wStrb, req_wValid, req_wLast,
        output m_arReady, m_rData, m_rValid, m_rLast, m_awReady, m_wReady,
        input  req_arReady, req_rData, req_rValid, req_rLast,
        input  req_awReady, req_wReady,
        input  m_rAddr, m_arLen, m_arValid, m_rReady,
        input  m_wAddr, m_awLen, m_awValid, m_wData, m_wStrb, m_wValid, m_wLast
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant of the first request at or after i_ptr (wrapping)
//   o_idx   : index of that grant
//   o_valid : at least one request present
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int unsigned w_j;
        w_j     = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = (32'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_j]) begin
                o_valid      = 1'b1;
                o_idx        = IW'(w_j);
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: multiplexes NUM_REQ requester ports onto one DRAM port. Read and write sides
// arbitrate independently (round-robin) and may run concurrently; a granted burst runs to
// completion before the next grant.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : dram_arbiter_if.slave (requester req_* ports and DRAM m_* port)
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned BURST_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    dram_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    // ---------------- read side ----------------
    arb_state_t             r_rd_state;
    logic [IW-1:0]          r_rd_ptr;
    logic [IW-1:0]          r_rd_gnt;
    logic [ADDR_WIDTH-1:0]  r_rd_addr;
    logic [BURST_WIDTH-1:0] r_rd_len;
    logic [BURST_WIDTH-1:0] r_rd_cnt;
    logic [NUM_REQ-1:0]     w_rd_onehot;
    logic [IW-1:0]          w_rd_idx;
    logic                   w_rd_any;
    logic                   w_rd_beat;
    logic [IW-1:0]          w_rd_ptr_nxt;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rd_arb (
        .i_req   (bus.req_arValid),
        .i_ptr   (r_rd_ptr),
        .o_grant (w_rd_onehot),
        .o_idx   (w_rd_idx),
        .o_valid (w_rd_any)
    );

    assign w_rd_beat    = bus.m_rValid && bus.req_rReady[r_rd_gnt];
    assign w_rd_ptr_nxt = (r_rd_gnt == IW'(NUM_REQ - 1)) ? '0 : r_rd_gnt + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= IDLE;
            r_rd_ptr   <= '0;
            r_rd_gnt   <= '0;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            case (r_rd_state)
                IDLE: begin
                    if (w_rd_any) begin
                        r_rd_gnt   <= w_rd_idx;
                        r_rd_addr  <= bus.req_rAddr[w_rd_idx];
                        r_rd_len   <= bus.req_arLen[w_rd_idx];
                        r_rd_cnt   <= '0;
                        r_rd_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_arReady) r_rd_state <= DATA;
                end
                DATA: begin
                    if (w_rd_beat) begin
                        // the DRAM's rLast ends a read burst, not the local count
                        if (bus.m_rLast) begin
                            r_rd_state <= IDLE;
                            r_rd_ptr   <= w_rd_ptr_nxt;
                            r_rd_cnt   <= '0;
                        end else begin
                            r_rd_cnt   <= r_rd_cnt + BURST_WIDTH'(1);
                        end
                    end
                end
                default: r_rd_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so a mid-burst reset forwards nothing.
    always_comb begin
        bus.req_arReady = '0;
        bus.m_arValid   = 1'b0;
        bus.m_rAddr     = '0;
        bus.m_arLen     = '0;
        bus.req_rData   = '0;
        bus.req_rValid  = '0;
        bus.req_rLast   = '0;
        bus.m_rReady    = 1'b0;
        if (!rst) begin
            case (r_rd_state)
                IDLE: bus.req_arReady = w_rd_onehot;
                ADDR: begin
                    bus.m_arValid = 1'b1;
                    bus.m_rAddr   = r_rd_addr;
                    bus.m_arLen   = r_rd_len;
                end
                DATA: begin
                    bus.req_rData[r_rd_gnt]  = bus.m_rData;
                    bus.req_rValid[r_rd_gnt] = bus.m_rValid;
                    bus.req_rLast[r_rd_gnt]  = bus.m_rLast;
                    bus.m_rReady             = bus.req_rReady[r_rd_gnt];
                end
                default: ;
            endcase
        end
    end

    // ---------------- write side ----------------
    arb_state_t             r_wr_state;
    logic [IW-1:0]          r_wr_ptr;
    logic [IW-1:0]          r_wr_gnt;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [BURST_WIDTH-1:0] r_wr_len;
    logic [BURST_WIDTH-1:0] r_wr_cnt;
    logic [NUM_REQ-1:0]     w_wr_onehot;
    logic [IW-1:0]          w_wr_idx;
    logic                   w_wr_any;
    logic                   w_wr_beat;
    logic                   w_wr_last;
    logic [IW-1:0]          w_wr_ptr_nxt;
    logic                   w_unused_wlast;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_wr_arb (
        .i_req   (bus.req_awValid),
        .i_ptr   (r_wr_ptr),
        .o_grant (w_wr_onehot),
        .o_idx   (w_wr_idx),
        .o_valid (w_wr_any)
    );

    // Requester wLast is ignored; the beat count against the latched len marks the end.
    assign w_unused_wlast = ^bus.req_wLast;
    assign w_wr_beat      = bus.req_wValid[r_wr_gnt] && bus.m_wReady;
    assign w_wr_last      = (r_wr_cnt == r_wr_len);
    assign w_wr_ptr_nxt   = (r_wr_gnt == IW'(NUM_REQ - 1)) ? '0 : r_wr_gnt + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= IDLE;
            r_wr_ptr   <= '0;
            r_wr_gnt   <= '0;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            case (r_wr_state)
                IDLE: begin
                    if (w_wr_any) begin
                        r_wr_gnt   <= w_wr_idx;
                        r_wr_addr  <= bus.req_wAddr[w_wr_idx];
                        r_wr_len   <= bus.req_awLen[w_wr_idx];
                        r_wr_cnt   <= '0;
                        r_wr_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_awReady) r_wr_state <= DATA;
                end
                DATA: begin
                    if (w_wr_beat) begin
                        if (w_wr_last) begin
                            r_wr_state <= IDLE;
                            r_wr_ptr   <= w_wr_ptr_nxt;
                            r_wr_cnt   <= '0;
                        end else begin
                            r_wr_cnt   <= r_wr_cnt + BURST_WIDTH'(1);
                        end
                    end
                end
                default: r_wr_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_awReady = '0;
        bus.req_wReady  = '0;
        bus.m_awValid   = 1'b0;
        bus.m_wAddr     = '0;
        bus.m_awLen     = '0;
        bus.m_wData     = '0;
        bus.m_wStrb     = '0;
        bus.m_wValid    = 1'b0;
        bus.m_wLast     = 1'b0;
        if (!rst) begin
            case (r_wr_state)
                IDLE: bus.req_awReady = w_wr_onehot;
                ADDR: begin
                    bus.m_awValid = 1'b1;
                    bus.m_wAddr   = r_wr_addr;
                    bus.m_awLen   = r_wr_len;
                end
                DATA: begin
                    bus.m_wData              = bus.req_wData[r_wr_gnt];
                    bus.m_wStrb              = bus.req_wStrb[r_wr_gnt];
                    bus.m_wValid             = bus.req_wValid[r_wr_gnt];
                    bus.m_wLast              = w_wr_last;
                    bus.req_wReady[r_wr_gnt] = bus.m_wReady;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized self-checking bench for dram_arbiter. Requesters and a DRAM
// responder are driven each negedge; a transaction-level model predicts every output.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int BW = 8;
    localparam int DW = DWIDTH;
    localparam int SW = SWIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) bus ();

    dram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // stimulus knobs (percent probabilities)
    int p_req, p_wd, p_arrdy, p_rvld, p_rrdy, p_awrdy, p_wrdy, p_wvld, max_len, stall_w;
    bit rst_req;

    // requester state
    bit              rd_pend [N];
    logic [AW-1:0]   rd_addr [N];
    logic [BW-1:0]   rd_len  [N];
    bit              wr_pend [N];
    logic [AW-1:0]   wr_addr [N];
    logic [BW-1:0]   wr_len  [N];
    logic [SW-1:0]   wr_strb [N];
    int              rcv_cnt [N];
    int              rcv_len [N];
    int              rbeats  [N];
    int              rd_done [N];
    int              wr_done [N];
    int              rd_order[$];
    int              wlast_cnt;

    // DRAM responder: beats still owed / expected
    int dr_left, dw_left;

    // reference model: one outstanding burst per side
    typedef struct {
        bit            act;
        bit            dat;
        int            port;
        logic [AW-1:0] addr;
        int            len;
        int            beats;
    } burst_t;
    burst_t mr, mw;
    int     mr_ptr, mw_ptr;

    function automatic bit roll(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic reset_model();
        mr = '{default: '0};
        mw = '{default: '0};
        mr_ptr = 0; mw_ptr = 0; dr_left = 0; dw_left = 0; stall_w = 0;
        for (int i = 0; i < N; i++) begin
            rd_pend[i] = 0; wr_pend[i] = 0; rcv_cnt[i] = 0; rcv_len[i] = 0;
            rd_addr[i] = '0; rd_len[i] = '0; wr_addr[i] = '0; wr_len[i] = '0; wr_strb[i] = '0;
        end
    endtask

    task automatic drive();
        rst = rst_req;
        for (int i = 0; i < N; i++) begin
            if (!rd_pend[i] && roll(p_req)) begin
                rd_pend[i] = 1; rd_addr[i] = AW'($urandom); rd_len[i] = BW'($urandom_range(max_len));
            end else if (rd_pend[i] && roll(p_wd)) rd_pend[i] = 0;
            if (!wr_pend[i] && roll(p_req)) begin
                wr_pend[i] = 1; wr_addr[i] = AW'($urandom); wr_len[i] = BW'($urandom_range(max_len));
                wr_strb[i] = SW'($urandom);
            end else if (wr_pend[i] && roll(p_wd)) wr_pend[i] = 0;
            bus.req_arValid[i] = rd_pend[i];
            bus.req_rAddr[i]   = rd_addr[i];
            bus.req_arLen[i]   = rd_len[i];
            bus.req_rReady[i]  = roll(p_rrdy);
            bus.req_awValid[i] = wr_pend[i];
            bus.req_wAddr[i]   = wr_addr[i];
            bus.req_awLen[i]   = wr_len[i];
            bus.req_wData[i]   = $urandom;
            bus.req_wStrb[i]   = wr_strb[i];
            bus.req_wValid[i]  = roll(p_wvld);
            bus.req_wLast[i]   = roll(50);
        end
        bus.m_arReady = roll(p_arrdy);
        bus.m_rValid  = (dr_left > 0) && roll(p_rvld);
        bus.m_rData   = $urandom;
        bus.m_rLast   = bus.m_rValid && (dr_left == 1);
        bus.m_awReady = roll(p_awrdy);
        bus.m_wReady  = roll(p_wrdy);
        if (stall_w > 0 && dw_left > 0) begin
            bus.m_wReady = 1'b0;
            stall_w--;
        end
    endtask

    task automatic evaluate();
        logic [N-1:0]         e_arrdy, e_rvld, e_rlast, e_awrdy, e_wrdy;
        logic [N-1:0][DW-1:0] e_rdata;
        logic                 e_arv, e_mrrdy, e_awv, e_wvld, e_wlast;
        logic [AW-1:0]        e_raddr, e_waddr;
        logic [BW-1:0]        e_arlen, e_awlen;
        logic [DW-1:0]        e_wdata;
        logic [SW-1:0]        e_wstrb;
        int                   gr, gw, p;
        e_arrdy = '0; e_rvld = '0; e_rlast = '0; e_awrdy = '0; e_wrdy = '0; e_rdata = '0;
        e_arv = 0; e_mrrdy = 0; e_awv = 0; e_wvld = 0; e_wlast = 0;
        e_raddr = '0; e_waddr = '0; e_arlen = '0; e_awlen = '0; e_wdata = '0; e_wstrb = '0;
        gr = -1; gw = -1;
        if (!rst) begin
            if (!mr.act) begin
                gr = pick(bus.req_arValid, mr_ptr);
                if (gr >= 0) e_arrdy[gr] = 1'b1;
            end else if (!mr.dat) begin
                e_arv = 1; e_raddr = mr.addr; e_arlen = BW'(mr.len);
            end else begin
                p = mr.port;
                e_rvld[p] = bus.m_rValid; e_rlast[p] = bus.m_rLast; e_rdata[p] = bus.m_rData;
                e_mrrdy = bus.req_rReady[p];
            end
            if (!mw.act) begin
                gw = pick(bus.req_awValid, mw_ptr);
                if (gw >= 0) e_awrdy[gw] = 1'b1;
            end else if (!mw.dat) begin
                e_awv = 1; e_waddr = mw.addr; e_awlen = BW'(mw.len);
            end else begin
                p = mw.port;
                e_wdata = bus.req_wData[p]; e_wstrb = bus.req_wStrb[p]; e_wvld = bus.req_wValid[p];
                e_wlast = (mw.beats == mw.len); e_wrdy[p] = bus.m_wReady;
            end
        end
        check_eq("arReady", bus.req_arReady, e_arrdy);
        check_eq("m_arValid", bus.m_arValid, e_arv);
        check_eq("m_rAddr", bus.m_rAddr, e_raddr);
        check_eq("m_arLen", bus.m_arLen, e_arlen);
        check_eq("rValid", bus.req_rValid, e_rvld);
        check_eq("rLast", bus.req_rLast, e_rlast);
        check_eq("rData", bus.req_rData, e_rdata);
        check_eq("m_rReady", bus.m_rReady, e_mrrdy);
        check_eq("awReady", bus.req_awReady, e_awrdy);
        check_eq("m_awValid", bus.m_awValid, e_awv);
        check_eq("m_wAddr", bus.m_wAddr, e_waddr);
        check_eq("m_awLen", bus.m_awLen, e_awlen);
        check_eq("m_wData", bus.m_wData, e_wdata);
        check_eq("m_wStrb", bus.m_wStrb, e_wstrb);
        check_eq("m_wValid", bus.m_wValid, e_wvld);
        check_eq("m_wLast", bus.m_wLast, e_wlast);
        check_eq("wReady", bus.req_wReady, e_wrdy);

        if (rst) begin
            reset_model();
            return;
        end
        // requester-side read scoreboard and DRAM responder bookkeeping (observed handshakes)
        for (int i = 0; i < N; i++) begin
            if (bus.req_rValid[i] && bus.req_rReady[i]) begin
                rcv_cnt[i]++; rbeats[i]++;
                if (bus.req_rLast[i]) begin
                    check_eq("rd_beats", rcv_cnt[i], rcv_len[i] + 1);
                    rcv_cnt[i] = 0;
                end
            end
        end
        if (bus.m_rValid && bus.m_rReady && dr_left > 0) dr_left--;
        if (bus.m_arValid && bus.m_arReady) dr_left = int'(bus.m_arLen) + 1;
        if (bus.m_wValid && bus.m_wReady) begin
            if (bus.m_wLast) begin
                check_eq("wlast_pos", dw_left, 1);
                wlast_cnt++;
            end
            if (dw_left > 0) dw_left--;
        end
        if (bus.m_awValid && bus.m_awReady) dw_left = int'(bus.m_awLen) + 1;

        // model: read side
        if (!mr.act) begin
            if (gr >= 0) begin
                mr = '{act: 1, dat: 0, port: gr, addr: rd_addr[gr], len: int'(rd_len[gr]), beats: 0};
                rcv_len[gr] = int'(rd_len[gr]);
                rd_pend[gr] = 0;
                rd_order.push_back(gr);
            end
        end else if (!mr.dat) begin
            if (bus.m_arReady) mr.dat = 1;
        end else if (bus.m_rValid && bus.req_rReady[mr.port]) begin
            mr.beats++;
            if (bus.m_rLast) begin
                mr.act = 0; mr_ptr = (mr.port + 1) % N; rd_done[mr.port]++;
            end
        end
        // model: write side
        if (!mw.act) begin
            if (gw >= 0) begin
                mw = '{act: 1, dat: 0, port: gw, addr: wr_addr[gw], len: int'(wr_len[gw]), beats: 0};
                wr_pend[gw] = 0;
            end
        end else if (!mw.dat) begin
            if (bus.m_awReady) mw.dat = 1;
        end else if (bus.req_wValid[mw.port] && bus.m_wReady) begin
            if (mw.beats == mw.len) begin
                mw.act = 0; mw_ptr = (mw.port + 1) % N; wr_done[mw.port]++;
            end else mw.beats++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        evaluate();
    endtask

    task automatic all_ready();
        p_req = 0; p_wd = 0; p_arrdy = 100; p_rvld = 100; p_rrdy = 100;
        p_awrdy = 100; p_wrdy = 100; p_wvld = 100;
    endtask

    initial begin
        int k, b0, w0;
        p_req = 0; p_wd = 0; p_arrdy = 0; p_rvld = 0; p_rrdy = 0;
        p_awrdy = 0; p_wrdy = 0; p_wvld = 0; max_len = 0; wlast_cnt = 0;
        for (int i = 0; i < N; i++) begin rbeats[i] = 0; rd_done[i] = 0; wr_done[i] = 0; end
        reset_model();
        rst_req = 1;
        drive();
        repeat (3) cycle();
        rst_req = 0;
        all_ready();
        cycle();

        // ports 0 and 2 request together: 0 first, then 2; pointer ends at 3
        rd_order.delete();
        rd_pend[0] = 1; rd_addr[0] = 14'h010; rd_len[0] = 8'd1;
        rd_pend[2] = 1; rd_addr[2] = 14'h020; rd_len[2] = 8'd0;
        for (k = 0; k < 60 && rd_done[2] == 0; k++) cycle();
        check_eq("rr_done", rd_done[2], 1);
        check_eq("rr_count", rd_order.size(), 2);
        if (rd_order.size() == 2) begin
            check_eq("rr_first", rd_order[0], 0);
            check_eq("rr_second", rd_order[1], 2);
        end
        cycle();
        check_eq("rr_ptr", dut.r_rd_ptr, 3);

        // port 1 reads 0x40, len 3: four beats, back to IDLE
        b0 = rbeats[1];
        rd_pend[1] = 1; rd_addr[1] = 14'h040; rd_len[1] = 8'd3;
        for (k = 0; k < 60 && rd_done[1] == 0; k++) cycle();
        check_eq("p1_done", rd_done[1], 1);
        check_eq("p1_beats", rbeats[1] - b0, 4);
        cycle();
        check_eq("p1_idle", dut.r_rd_state, IDLE);

        // port 3 writes len 1, strb 0xF, DRAM stalls wReady 2 cycles
        w0 = wlast_cnt;
        wr_pend[3] = 1; wr_addr[3] = 14'h100; wr_len[3] = 8'd1; wr_strb[3] = 4'hF;
        stall_w = 2;
        for (k = 0; k < 60 && wr_done[3] == 0; k++) cycle();
        check_eq("p3_done", wr_done[3], 1);
        check_eq("p3_wlast_cnt", wlast_cnt - w0, 1);
        check_eq("p3_stall_used", stall_w, 0);

        // concurrent read on port 0 and write on port 1
        rd_pend[0] = 1; rd_addr[0] = 14'h200; rd_len[0] = 8'd2;
        wr_pend[1] = 1; wr_addr[1] = 14'h300; wr_len[1] = 8'd2; wr_strb[1] = 4'h5;
        for (k = 0; k < 60 && (rd_done[0] < 2 || wr_done[1] == 0); k++) cycle();
        check_eq("conc_rd", rd_done[0], 2);
        check_eq("conc_wr", wr_done[1], 1);

        // reset during the second beat of a len 3 read
        rd_pend[0] = 1; rd_addr[0] = 14'h080; rd_len[0] = 8'd3;
        for (k = 0; k < 60 && !(mr.act && mr.dat && mr.beats == 1); k++) cycle();
        check_eq("rst_reach", mr.beats, 1);
        rst_req = 1;
        cycle();
        rst_req = 0;
        cycle();
        check_eq("rst_quiet", {bus.req_arReady, bus.req_rValid, bus.req_rLast, bus.m_arValid,
                               bus.m_rReady, bus.req_awReady, bus.m_awValid, bus.m_wValid,
                               bus.req_wReady, bus.m_rAddr, bus.req_rData}, '0);
        check_eq("rst_idle", dut.r_rd_state, IDLE);
        check_eq("rst_ptr", dut.r_rd_ptr, 0);
        b0 = rd_done[2];
        rd_pend[2] = 1; rd_addr[2] = 14'h044; rd_len[2] = 8'd0;
        for (k = 0; k < 60 && rd_done[2] == b0; k++) cycle();
        check_eq("rst_regrant", rd_done[2], b0 + 1);

        // randomized segments
        for (int s = 0; s < 8; s++) begin
            p_req = $urandom_range(60, 15); p_wd = $urandom_range(10);
            p_arrdy = $urandom_range(100, 30); p_rvld = $urandom_range(100, 30);
            p_rrdy = $urandom_range(100, 30); p_awrdy = $urandom_range(100, 30);
            p_wrdy = $urandom_range(100, 30); p_wvld = $urandom_range(100, 30);
            max_len = $urandom_range(7);
            repeat (300) cycle();
        end
        all_ready();
        repeat (150) cycle();
        check_eq("drain_rd_idle", dut.r_rd_state, IDLE);
        check_eq("drain_wr_idle", dut.r_wr_state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
